// File: rtl/single_cycle_mips_core.sv
// Single-cycle, word-addressed 32-bit MIPS-style core.
// It contains its own instruction memory, register file, ALU and data memory.
// Instruction memory is filled through a write port while instruction_Write_en
// is high, and the core is frozen during that time. Otherwise the core commits
// one instruction per rising clock edge.
module single_cycle_mips_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_Write_en,
  input  logic [31:0] Write_address,
  input  logic [31:0] Write_instruction,
  output logic [31:0] ALU_Result,
  output logic [31:0] Register_file_Write_Data
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd6;
  localparam logic [5:0] OP_SLTI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd2;
  localparam logic [5:0] OP_SW    = 6'd4;
  localparam logic [5:0] OP_J     = 6'd10;
  localparam logic [5:0] OP_JAL   = 6'd12;
  localparam logic [5:0] OP_JR    = 6'd14;
  localparam logic [5:0] OP_BEQ   = 6'd16;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_SLT = 6'd3;
  localparam logic [5:0] FN_AND = 6'd4;
  localparam logic [5:0] FN_OR  = 6'd5;

  logic [31:0] r_pc;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_dmem [DMEM_DEPTH];
  logic [31:0] r_regs [32];

  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_simm;
  logic [31:0] w_uimm;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_pc_plus1;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_alu;
  logic [31:0] w_wd;
  logic        w_reg_we;
  logic [4:0]  w_reg_wa;
  logic        w_dmem_we;
  logic [31:0] w_next_pc;
  logic        w_run;
  logic        w_unused;

  assign w_instr     = r_imem[r_pc[IAW-1:0]];
  assign w_op        = w_instr[31:26];
  assign w_rs        = w_instr[25:21];
  assign w_rt        = w_instr[20:16];
  assign w_rd        = w_instr[15:11];
  assign w_funct     = w_instr[5:0];
  assign w_simm      = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_uimm      = {16'd0, w_instr[15:0]};
  assign w_rs_val    = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val    = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
  assign w_pc_plus1  = r_pc + 32'd1;
  assign w_mem_rdata = r_dmem[w_alu[DAW-1:0]];
  assign w_run       = reset && !instruction_Write_en;
  assign w_unused    = ^{Write_address[31:IAW], w_instr[10:6]};

  // Decode and execute the current instruction: ALU value, write-back and next PC
  always_comb begin
    w_alu     = 32'd0;
    w_reg_we  = 1'b0;
    w_reg_wa  = w_rd;
    w_dmem_we = 1'b0;
    w_next_pc = w_pc_plus1;
    case (w_op)
      OP_RTYPE: begin
        w_reg_wa = w_rd;
        w_reg_we = 1'b1;
        case (w_funct)
          FN_ADD:  w_alu = w_rs_val + w_rt_val;
          FN_SUB:  w_alu = w_rs_val - w_rt_val;
          FN_SLT:  w_alu = ($signed(w_rs_val) < $signed(w_rt_val)) ? 32'd1 : 32'd0;
          FN_AND:  w_alu = w_rs_val & w_rt_val;
          FN_OR:   w_alu = w_rs_val | w_rt_val;
          default: w_reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_alu    = w_rs_val + w_simm;
        w_reg_wa = w_rt;
        w_reg_we = 1'b1;
      end
      OP_SLTI: begin
        w_alu    = ($signed(w_rs_val) < $signed(w_simm)) ? 32'd1 : 32'd0;
        w_reg_wa = w_rt;
        w_reg_we = 1'b1;
      end
      OP_LW: begin
        w_alu    = w_rs_val + w_simm;
        w_reg_wa = w_rt;
        w_reg_we = 1'b1;
      end
      OP_SW: begin
        w_alu     = w_rs_val + w_simm;
        w_dmem_we = 1'b1;
      end
      OP_J: w_next_pc = {6'd0, w_instr[25:0]};
      OP_JAL: begin
        w_reg_wa  = w_rs;
        w_reg_we  = 1'b1;
        w_next_pc = {11'd0, w_instr[20:0]};
      end
      OP_JR: w_next_pc = w_rs_val;
      OP_BEQ: begin
        w_alu = w_rs_val - w_rt_val;
        if (w_rs_val == w_rt_val) w_next_pc = w_uimm;
      end
      default: ;
    endcase
    if (w_op == OP_LW)       w_wd = w_mem_rdata;
    else if (w_op == OP_JAL) w_wd = w_pc_plus1;
    else                     w_wd = w_alu;
  end

  // Outputs are held at zero while reset is asserted
  assign ALU_Result               = reset ? w_alu : 32'd0;
  assign Register_file_Write_Data = reset ? w_wd  : 32'd0;

  // Instruction memory load port; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && instruction_Write_en) r_imem[Write_address[IAW-1:0]] <= Write_instruction;
  end

  // Architectural state: PC, register file and data memory
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= 32'd0;
    end else if (w_run) begin
      r_pc <= w_next_pc;
      if (w_reg_we && (w_reg_wa != 5'd0)) r_regs[w_reg_wa] <= w_wd;
      if (w_dmem_we) r_dmem[w_alu[DAW-1:0]] <= w_rt_val;
    end
  end

endmodule

// File: tb/tb_single_cycle_mips_core.sv
// Bench for single_cycle_mips_core: a directed program plus random programs,
// checked cycle by cycle against an instruction-level reference model.
module tb_single_cycle_mips_core;

  logic        clk;
  logic        reset;
  logic        instruction_Write_en;
  logic [31:0] Write_address;
  logic [31:0] Write_instruction;
  logic [31:0] ALU_Result;
  logic [31:0] Register_file_Write_Data;

  single_cycle_mips_core dut (
    .clk                      (clk),
    .reset                    (reset),
    .instruction_Write_en     (instruction_Write_en),
    .Write_address            (Write_address),
    .Write_instruction        (Write_instruction),
    .ALU_Result               (ALU_Result),
    .Register_file_Write_Data (Register_file_Write_Data)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference machine state
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;
  logic [31:0] prog   [256];
  int          arr    [20];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {op[5:0], tgt[25:0]};
  endfunction

  function automatic logic [31:0] enc_jal(input int rs, input int tgt);
    return {6'd12, rs[4:0], tgt[20:0]};
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_reg[r];
  endfunction

  // Model one clock edge: return the outputs seen before the edge, then apply the edge
  task automatic model_step(output logic [31:0] alu, output logic [31:0] wd);
    logic [31:0] ins, a, b, simm, pc1, nxt;
    int op, fn, dest;
    alu = 0;
    wd  = 0;
    if (!reset) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      for (int i = 0; i < 256; i++) m_dmem[i] = 0;
      return;
    end
    ins  = m_imem[m_pc[7:0]];
    op   = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    a    = rd_reg(ins[25:21]);
    b    = rd_reg(ins[20:16]);
    simm = {{16{ins[15]}}, ins[15:0]};
    pc1  = m_pc + 1;
    nxt  = pc1;
    dest = -1;
    case (op)
      0: begin
        dest = int'(ins[15:11]);
        if (fn == 0)      alu = a + b;
        else if (fn == 1) alu = a - b;
        else if (fn == 3) alu = ($signed(a) < $signed(b)) ? 1 : 0;
        else if (fn == 4) alu = a & b;
        else if (fn == 5) alu = a | b;
        else              dest = -1;
      end
      6:  begin alu = a + simm; dest = int'(ins[20:16]); end
      8:  begin alu = ($signed(a) < $signed(simm)) ? 1 : 0; dest = int'(ins[20:16]); end
      2:  begin alu = a + simm; dest = int'(ins[20:16]); end
      4:  alu = a + simm;
      10: nxt = {6'd0, ins[25:0]};
      12: begin dest = int'(ins[25:21]); nxt = {11'd0, ins[20:0]}; end
      14: nxt = a;
      16: begin alu = a - b; if (a == b) nxt = {16'd0, ins[15:0]}; end
      default: ;
    endcase
    wd = (op == 2) ? m_dmem[alu[7:0]] : (op == 12) ? pc1 : alu;
    if (instruction_Write_en) begin
      m_imem[Write_address[7:0]] = Write_instruction;
    end else begin
      if (op == 4) m_dmem[alu[7:0]] = b;
      if (dest > 0) m_reg[dest] = wd;
      m_pc = nxt;
    end
  endtask

  // One clock: compare DUT outputs with the model, then advance both
  task automatic cycle(input bit chk);
    logic [31:0] ea, ew;
    #1;
    model_step(ea, ew);
    if (chk) begin
      check("alu_result", ALU_Result, ea);
      check("rf_write_data", Register_file_Write_Data, ew);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_program(input bit chk);
    reset = 1'b1;
    instruction_Write_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      Write_address     = 32'(i) | ({24'($urandom), 8'd0});
      Write_instruction = prog[i];
      cycle(chk);
    end
    instruction_Write_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int ops[10] = '{0, 0, 6, 8, 2, 4, 10, 12, 14, 16};
    int fns[7]  = '{0, 1, 3, 4, 5, 2, 63};
    int op;
    op = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 9)];
    case (op)
      0:  return enc_r(fns[$urandom_range(0, 6)], $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      10: return enc_j(10, ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 255)));
      12: return enc_jal($urandom_range(0, 31), $urandom_range(0, 255));
      16: return enc_i(16, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 255));
      default: return enc_i(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    int exp_max, exp_idx;
    for (int i = 0; i < 256; i++) begin
      m_imem[i] = 0;
      prog[i]   = 0;
    end
    m_pc = 0;
    reset = 1'b0;
    instruction_Write_en = 1'b0;
    Write_address = 0;
    Write_instruction = 0;
    @(negedge clk);
    cycle(1'b0);
    cycle(1'b0);
    check("reset_alu_zero", ALU_Result, 32'd0);
    check("reset_wd_zero", Register_file_Write_Data, 32'd0);

    // Directed program
    for (int i = 1; i <= 12; i++) prog[i-1] = enc_i(6, i, 0, i + 5);
    prog[12] = enc_r(0, 13, 1, 2);
    prog[13] = enc_r(1, 14, 4, 3);
    prog[14] = enc_r(3, 15, 5, 6);
    prog[15] = enc_r(4, 16, 7, 8);
    prog[16] = enc_r(5, 17, 9, 10);
    prog[17] = enc_i(8, 18, 11, 10);
    prog[18] = enc_i(4, 17, 5, 80);
    prog[19] = enc_i(2, 19, 5, 80);
    prog[20] = enc_i(16, 19, 17, 23);
    prog[21] = enc_i(6, 20, 0, 99);
    prog[22] = enc_i(6, 20, 0, 99);
    prog[23] = enc_i(16, 2, 1, 5);
    prog[24] = enc_j(10, 26);
    prog[25] = enc_i(6, 20, 0, 77);
    prog[26] = enc_j(10, 61);
    prog[61] = enc_jal(21, 50);
    prog[50] = enc_i(6, 23, 0, 40);
    prog[51] = enc_i(14, 0, 23, 0);
    prog[40] = enc_j(10, 120);
    exp_max = -1;
    exp_idx = 0;
    for (int k = 0; k < 20; k++) begin
      arr[k] = int'($urandom_range(0, 1000));
      if (arr[k] > exp_max) begin
        exp_max = arr[k];
        exp_idx = 51 + k;
      end
      prog[120 + 2*k] = enc_i(6, 24, 0, arr[k]);
      prog[121 + 2*k] = enc_i(4, 24, 0, 51 + k);
    end
    prog[160] = enc_i(6, 23, 0, 51);
    prog[161] = enc_i(2, 22, 23, 0);
    prog[162] = enc_i(6, 25, 0, 52);
    prog[163] = enc_i(6, 26, 0, 71);
    prog[164] = enc_i(16, 26, 25, 172);
    prog[165] = enc_i(2, 27, 25, 0);
    prog[166] = enc_r(3, 28, 22, 27);
    prog[167] = enc_i(16, 0, 28, 170);
    prog[168] = enc_r(0, 22, 27, 0);
    prog[169] = enc_r(0, 23, 25, 0);
    prog[170] = enc_i(6, 25, 25, 1);
    prog[171] = enc_j(10, 164);
    prog[172] = enc_r(0, 29, 22, 0);
    prog[173] = enc_r(0, 30, 23, 0);
    prog[174] = enc_j(10, 174);

    reset = 1'b0;
    cycle(1'b0);
    load_program(1'b0);
    for (int c = 0; c < 800 && m_pc != 172; c++) begin
      #1;
      case (m_pc)
        0:  check("first_addi", ALU_Result, 32'd6);
        12: check("add_r13", ALU_Result, 32'd13);
        13: check("sub_r14", ALU_Result, 32'd1);
        14: check("slt_r15", ALU_Result, 32'd1);
        15: check("and_r16", ALU_Result, 32'd12);
        16: check("or_r17", ALU_Result, 32'd15);
        17: check("slti_r18", ALU_Result, 32'd0);
        18: check("sw_addr", ALU_Result, 32'd90);
        19: check("lw_data", Register_file_Write_Data, 32'd15);
        20: check("beq_diff", ALU_Result, 32'd0);
        61: check("jal_link", Register_file_Write_Data, 32'd62);
        default: ;
      endcase
      cycle(1'b1);
    end
    check("max_loop_reached", m_pc, 32'd172);
    #1;
    check("array_max", ALU_Result, 32'(exp_max));
    cycle(1'b1);
    #1;
    check("array_max_idx", ALU_Result, 32'(exp_idx));
    cycle(1'b1);

    // Load mode freezes the core; reset mid-run restarts the kept program
    instruction_Write_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Write_address = 32'(200 + i);
      Write_instruction = $urandom;
      cycle(1'b1);
    end
    instruction_Write_en = 1'b0;
    reset = 1'b0;
    cycle(1'b1);
    check("midrun_reset_alu", ALU_Result, 32'd0);
    check("midrun_reset_wd", Register_file_Write_Data, 32'd0);
    reset = 1'b1;
    #1;
    check("restart_first_addi", ALU_Result, 32'd6);
    for (int i = 0; i < 30; i++) cycle(1'b1);

    // Random programs
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++) prog[i] = rand_instr();
      reset = 1'b0;
      cycle(1'b1);
      load_program(1'b1);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 99) == 0) reset = 1'b0;
        if ($urandom_range(0, 59) == 0) begin
          instruction_Write_en = 1'b1;
          Write_address = $urandom;
          Write_instruction = rand_instr();
        end
        cycle(1'b1);
        reset = 1'b1;
        instruction_Write_en = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
